plab4_net_output_credit_arbiter: RTL
====================================

# plab4_net_output_credit_arbiter

Per-output-port controller for the ring router. It shares one output channel among the router's input units (terminal, prev, next) with a round-robin arbiter and tracks the free-slot credits of the downstream input buffer. The registered credit count is exported as the `num_free_chanX` value consumed by the adaptive route compute, so routing decisions see real downstream congestion. One instance sits on each of the three router output ports.

## Interface

Parameters:
- `p_num_reqs`, 3: number of requesting input units; bit i maps to input unit i.
- `p_num_credits`, 2: downstream buffer depth and the reset credit count.
- `c_credit_nbits`, derived as `$clog2(p_num_credits+1)`: credit counter width (2 for the defaults).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on the rising `clk` edge.
- `reqs`  in  p_num_reqs  input unit i has a flit routed to this output.
- `grants`  out  p_num_reqs  one-hot or zero; the granted unit sends its flit this cycle.
- `out_val`  out  1  a flit crosses the output channel this cycle (equals `|grants`).
- `credit_return`  in  1  downstream freed one buffer slot this cycle.
- `num_free`  out  c_credit_nbits  registered credit count; drives route compute.
- `credit_err`  out  1  sticky flag set when a credit is returned while the count is already at `p_num_credits`.

## Operation

- State registers:
  - `cnt`: credit count, 0..p_num_credits.
  - `ptr`: round-robin priority pointer, 0..p_num_reqs-1.
  - `err`: sticky error bit.
- Reset values: `cnt` = p_num_credits, `ptr` = 0, `err` = 0.
- Outputs while `reset` = 0: `grants` = 0 and `out_val` = 0, regardless of `reqs`.
- Grant eligibility: `avail` = (cnt != 0). The bypass extension is described under Configuration.
- Arbitration:
  - When `avail` is true, search from index `ptr` upward, wrapping modulo p_num_reqs.
  - The first asserted `reqs` bit wins, and its `grants` bit is set.
  - When `avail` is false or `reqs` = 0, `grants` = 0.
- Pointer update: on a grant to index w, `ptr` <= (w+1) mod p_num_reqs. Without a grant, `ptr` holds.
- Credit update: with g = `out_val` and r = `credit_return`:
  - `cnt` <= cnt − g + r.
  - A simultaneous g and r leaves `cnt` unchanged.
- Overflow: if r = 1, g = 0 and cnt = p_num_credits, then `cnt` saturates (holds) and `err` <= 1.
- `err` clears only on reset.
- Underflow is impossible by construction: no grant is issued at cnt = 0 unless the bypass is enabled.
- Requesters own flow control. A unit keeps `reqs` high until it sees its grant, then dequeues its flit in the same cycle. Deasserting `reqs` without a grant is legal.

## Timing

- `grants` and `out_val` are combinational from `reqs`, `cnt` and `ptr` (plus `credit_return` under bypass), giving zero-cycle grant latency.
- `num_free` = `cnt`, a pure register output with no combinational path from `reqs` or `credit_return`. A credit consumed or returned in cycle n is visible on `num_free` in cycle n+1.
- `credit_err` is registered and asserts the cycle after the overflowing return.
- Throughput is one grant per cycle while credits last. With continuous credit returns, one flit per cycle is sustained indefinitely.
- Reset asserted mid-operation discards any in-flight credit accounting. Counts return to reset values on the next edge, and the surrounding router is reset with it.

## Configuration

- `PLAB4_NET_OUTPUT_CREDIT_BYPASS_EN`:
  - Defined: `avail` = (cnt != 0) | credit_return. A credit returned in cycle n can be spent by a grant in cycle n. At cnt = 0 with a simultaneous grant and return, `cnt` stays 0.
  - Undefined: `avail` = (cnt != 0). A returned credit becomes usable in cycle n+1.
- The macro has no effect on `num_free` timing.

## Test plan

All scenarios use p_num_reqs = 3 and p_num_credits = 2.

- Reset: hold `reset` = 0 for 2 cycles with `reqs` = 3'b111, then release. Required: `grants` = 0 during reset; after release `num_free` = 2, `credit_err` = 0, and the first grant is 3'b001.
- Round-robin fairness: `reqs` = 3'b111 and `credit_return` = 1 every cycle for 4 cycles. Required: `grants` = 001, 010, 100, 001; `num_free` stays 2; `credit_err` stays 0.
- Credit exhaustion: `reqs` = 3'b001, no returns. Required:
  - `grants` = 001 in cycles 0 and 1, then 000 in cycle 2.
  - `num_free` goes 2 → 1 → 0.
  - With `credit_return` = 1 in cycle 3: the next grant is in cycle 4 without the macro, and in cycle 3 with it.
- Pointer hold and wrap:
  - `reqs` = 3'b010 yields grant 010, setting `ptr` to 2.
  - Then 3 idle cycles with `reqs` = 0.
  - Then `reqs` = 3'b011. Required: grant 001, because the search from 2 wraps to 0.
- Overflow: at `num_free` = 2, `reqs` = 0, pulse `credit_return` = 1. Required: `num_free` stays 2, and `credit_err` = 1 next cycle and stays 1 until reset.
- Reset mid-operation: drive to `num_free` = 0, `ptr` = 2, `credit_err` = 1, then `reset` = 0 for one cycle. Required: `num_free` = 2, `credit_err` = 0, and `reqs` = 3'b111 then grants 001.

Source files
------------

// File: rtl/plab4_net_output_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : plab4_net_output_credit_arbiter
//  Purpose  : Per-output-port controller for the ring router. Shares one
//             output channel among the input units with a round-robin
//             arbiter and tracks free-slot credits of the downstream input
//             buffer. The registered credit count (num_free) feeds the
//             adaptive route compute.
//  Ports    : clk           - clock, all state updates on rising edge
//             reset         - synchronous, active-low (0 = reset)
//             reqs          - request vector, bit i = input unit i
//             grants        - one-hot or zero grant vector (combinational)
//             out_val       - a flit crosses the channel this cycle
//             credit_return - downstream freed one buffer slot this cycle
//             num_free      - registered credit count
//             credit_err    - sticky credit-overflow flag (registered)
//  Config   : PLAB4_NET_OUTPUT_CREDIT_BYPASS_EN
//             When defined, a credit returned in cycle n can be spent by a
//             grant in the same cycle n (zero-credit bypass).
//  Revision : 1.0 - initial release
// ============================================================================

module plab4_net_output_credit_arbiter #(
    parameter  int p_num_reqs     = 3,
    parameter  int p_num_credits  = 2,
    localparam int c_credit_nbits = $clog2(p_num_credits + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_num_reqs-1:0]     reqs,
    output logic [p_num_reqs-1:0]     grants,
    output logic                      out_val,
    input  logic                      credit_return,
    output logic [c_credit_nbits-1:0] num_free,
    output logic                      credit_err
);

    // Pointer width; a single requester still needs a one-bit pointer.
    localparam int c_ptr_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

    localparam logic [c_credit_nbits-1:0] c_cnt_max  = c_credit_nbits'(p_num_credits);
    localparam logic [c_credit_nbits-1:0] c_cnt_one  = c_credit_nbits'(1);
    localparam logic [c_ptr_nbits-1:0]    c_ptr_last = c_ptr_nbits'(p_num_reqs - 1);
    localparam logic [c_ptr_nbits-1:0]    c_ptr_one  = c_ptr_nbits'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [c_credit_nbits-1:0] cnt_q, cnt_d;
    logic [c_ptr_nbits-1:0]    ptr_q, ptr_d;
    logic                      err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic                   avail;
    logic                   found;
    logic [c_ptr_nbits-1:0] win_idx;
    int                     idx;

`ifdef PLAB4_NET_OUTPUT_CREDIT_BYPASS_EN
    // A credit arriving this cycle may be spent immediately.
    assign avail = (cnt_q != '0) | credit_return;
`else
    assign avail = (cnt_q != '0);
`endif

    // Search from ptr upward with wrap; the first asserted request wins.
    // Grants are forced low while reset is asserted so no flit leaves a
    // router that is being reset.
    always_comb begin
        grants  = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        if (reset && avail) begin
            for (int i = 0; i < p_num_reqs; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= p_num_reqs) begin
                    idx = idx - p_num_reqs;
                end
                if (!found && reqs[idx]) begin
                    found       = 1'b1;
                    grants[idx] = 1'b1;
                    win_idx     = c_ptr_nbits'(idx);
                end
            end
        end
    end

    assign out_val = found;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;

        // Priority moves to the unit just after the winner.
        if (found) begin
            ptr_d = (win_idx == c_ptr_last) ? '0 : (win_idx + c_ptr_one);
        end

        // cnt <= cnt - g + r. A simultaneous grant and return cancel, which
        // also covers the bypass case at cnt = 0 (count stays 0).
        unique case ({found, credit_return})
            2'b10: cnt_d = cnt_q - c_cnt_one;
            2'b01: begin
                if (cnt_q == c_cnt_max) begin
                    // Downstream returned more credits than it owns:
                    // saturate and flag it until the next reset.
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State register, synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= c_cnt_max;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign num_free   = cnt_q;
    assign credit_err = err_q;

endmodule

`default_nettype wire
